// File: rtl/m6809_bus_pkg.sv
// rtl/m6809_bus_pkg.sv - shared types and constants for the m6809 boot bus controller
package m6809_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } bus_state_t;

    localparam logic [7:0] ROM_PAGE_DEF      = 8'hFF;
    localparam logic       BUS_ERR_ROM_WRITE = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/boot_bus_ctl.sv
// rtl/boot_bus_ctl.sv - m6809 memory-port cycle controller for boot ROM and async RAM
module boot_bus_ctl
    import m6809_bus_pkg::*;
#(
    parameter logic [7:0] ROM_PAGE = ROM_PAGE_DEF,
    parameter int         ROM_WAIT = 2,
    parameter int         RAM_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        bus_err,
    output logic        rom_sel,
    output logic [7:0]  rom_a,
    input  logic [7:0]  rom_dout,
    output logic        ram_cs_n,
    output logic        ram_we_n,
    output logic [15:0] ram_a,
    output logic [7:0]  ram_dq_o,
    input  logic [7:0]  ram_dq_i
);

    localparam int MAX_WAIT = max_int(ROM_WAIT, RAM_WAIT);
    localparam int CNT_W    = max_int(1, $clog2(MAX_WAIT));
    localparam logic [CNT_W-1:0] ROM_CNT = CNT_W'(ROM_WAIT - 1);
    localparam logic [CNT_W-1:0] RAM_CNT = CNT_W'(RAM_WAIT - 1);

    bus_state_t       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             we_q, we_d;
    logic             is_rom_q, is_rom_d;
    logic             is_rom;
    logic [7:0]       cpu_rdata_d;
    logic             cpu_ack_d, bus_err_d;
    logic             rom_sel_d, ram_cs_n_d, ram_we_n_d;
    logic [7:0]       rom_a_d, ram_dq_o_d;
    logic [15:0]      ram_a_d;

    assign is_rom = (cpu_addr[15:8] == ROM_PAGE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // All bus-facing outputs are registered so strobes are glitch-free at the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            we_q      <= 1'b0;
            is_rom_q  <= 1'b0;
            cpu_rdata <= 8'h00;
            cpu_ack   <= 1'b0;
            bus_err   <= 1'b0;
            rom_sel   <= 1'b0;
            rom_a     <= 8'h00;
            ram_cs_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            ram_a     <= 16'h0000;
            ram_dq_o  <= 8'h00;
        end else begin
            cnt       <= cnt_d;
            we_q      <= we_d;
            is_rom_q  <= is_rom_d;
            cpu_rdata <= cpu_rdata_d;
            cpu_ack   <= cpu_ack_d;
            bus_err   <= bus_err_d;
            rom_sel   <= rom_sel_d;
            rom_a     <= rom_a_d;
            ram_cs_n  <= ram_cs_n_d;
            ram_we_n  <= ram_we_n_d;
            ram_a     <= ram_a_d;
            ram_dq_o  <= ram_dq_o_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        we_d        = we_q;
        is_rom_d    = is_rom_q;
        cpu_rdata_d = cpu_rdata;
        cpu_ack_d   = 1'b0;
        bus_err_d   = 1'b0;
        rom_sel_d   = rom_sel;
        rom_a_d     = rom_a;
        ram_cs_n_d  = ram_cs_n;
        ram_we_n_d  = ram_we_n;
        ram_a_d     = ram_a;
        ram_dq_o_d  = ram_dq_o;

        unique case (state)
            IDLE: begin
                if (cpu_req) begin
                    we_d     = cpu_we;
                    is_rom_d = is_rom;
                    if (is_rom && cpu_we) begin
                        // ROM is never strobed for a write; report it straight away.
                        state_d   = ACK;
                        cpu_ack_d = 1'b1;
                        bus_err_d = BUS_ERR_ROM_WRITE;
                    end else if (is_rom) begin
                        state_d   = ACCESS;
                        cnt_d     = ROM_CNT;
                        rom_sel_d = 1'b1;
                        rom_a_d   = cpu_addr[7:0];
                    end else begin
                        state_d    = ACCESS;
                        cnt_d      = RAM_CNT;
                        ram_cs_n_d = 1'b0;
                        ram_we_n_d = ~cpu_we;
                        ram_a_d    = cpu_addr;
                        ram_dq_o_d = cpu_wdata;
                    end
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    if (!we_q) begin
                        cpu_rdata_d = is_rom_q ? rom_dout : ram_dq_i;
                    end
                    rom_sel_d  = 1'b0;
                    ram_cs_n_d = 1'b1;
                    ram_we_n_d = 1'b1;
                    cpu_ack_d  = 1'b1;
                    state_d    = ACK;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_boot_bus_ctl.sv
// tb/tb_boot_bus_ctl.sv - self-checking bench for boot_bus_ctl
module tb_boot_bus_ctl;

    localparam int ROM_WAIT = 2;
    localparam int RAM_WAIT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack, bus_err, rom_sel, ram_cs_n, ram_we_n;
    logic [7:0]  rom_a, rom_dout, ram_dq_o, ram_dq_i;
    logic [15:0] ram_a;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    boot_bus_ctl #(.ROM_PAGE(8'hFF), .ROM_WAIT(ROM_WAIT), .RAM_WAIT(RAM_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .bus_err(bus_err),
        .rom_sel(rom_sel), .rom_a(rom_a), .rom_dout(rom_dout),
        .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n), .ram_a(ram_a),
        .ram_dq_o(ram_dq_o), .ram_dq_i(ram_dq_i)
    );

    function automatic logic [7:0] rom_fn(input logic [7:0] off);
        if (off == 8'h00) return 8'h4F;
        if (off == 8'hFE) return 8'hFF;
        return off ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_init(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    // Memory devices seen by the DUT.
    logic [7:0] ram_mem [0:65535];
    assign rom_dout = rom_fn(rom_a);
    assign ram_dq_i = ram_mem[ram_a];
    always @(posedge clk) begin
        if (!ram_cs_n && !ram_we_n) ram_mem[ram_a] <= ram_dq_o;
    end

    // Transaction-level reference: byte store plus last value returned to the core.
    logic [7:0] ref_mem [int];
    logic [7:0] ref_rdata;

    function automatic logic [7:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return ram_init(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rd;
        logic        err;
        int          lat;
        int          nrom;
        int          ncs;
        int          nwe;
    } vec_t;

    int          r_lat, r_acks, r_rom, r_cs, r_we;
    logic [7:0]  r_rd;
    logic        r_err;
    bit          r_addr_ok;

    task automatic run_txn(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                           input bit extra);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        r_lat = -1; r_acks = 0; r_rom = 0; r_cs = 0; r_we = 0;
        r_rd = 8'hxx; r_err = 1'bx; r_addr_ok = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (rom_sel) begin
                r_rom++;
                if (rom_a !== addr[7:0]) r_addr_ok = 1'b0;
            end
            if (!ram_cs_n) begin
                r_cs++;
                if (ram_a !== addr || (we && ram_dq_o !== wd)) r_addr_ok = 1'b0;
                if (!ram_we_n) r_we++;
            end
            if (cpu_ack) begin
                r_acks++;
                if (r_lat < 0) begin
                    r_lat = n; r_rd = cpu_rdata; r_err = bus_err;
                end
            end
            if (extra && n == 0) begin
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr ^ 16'h0100;
            end else begin
                cpu_req = 1'b0;
            end
        end
    endtask

    task automatic check_txn(input string tag, input vec_t v);
        chk({tag, " latency"}, r_lat, v.lat);
        chk({tag, " ack count"}, r_acks, 1);
        chk({tag, " rdata"}, r_rd, v.rd);
        chk({tag, " bus_err"}, r_err, v.err);
        chk({tag, " rom_sel cycles"}, r_rom, v.nrom);
        chk({tag, " ram_cs_n cycles"}, r_cs, v.ncs);
        chk({tag, " ram_we_n cycles"}, r_we, v.nwe);
        chk({tag, " address/data"}, r_addr_ok, 1);
    endtask

    function automatic vec_t predict(input logic we, input logic [15:0] a, input logic [7:0] wd);
        vec_t v;
        bit rom = (a[15:8] == 8'hFF);
        v.we = we; v.addr = a; v.wdata = wd;
        v.err = 1'b0; v.nrom = 0; v.ncs = 0; v.nwe = 0;
        if (rom && we) begin
            v.err = 1'b1; v.lat = 0;
        end else if (rom) begin
            ref_rdata = rom_fn(a[7:0]);
            v.lat = ROM_WAIT; v.nrom = ROM_WAIT;
        end else begin
            v.lat = RAM_WAIT; v.ncs = RAM_WAIT;
            if (we) begin
                ref_mem[int'(a)] = wd;
                v.nwe = RAM_WAIT;
            end else begin
                ref_rdata = ref_read(a);
            end
        end
        v.rd = ref_rdata;
        return v;
    endfunction

    vec_t vecs [7];

    initial begin
        for (int i = 0; i < 65536; i++) ram_mem[i] = ram_init(16'(i));

        vecs[0] = '{1'b0, 16'hFFFE, 8'h00, 8'hFF, 1'b0, 2, 2, 0, 0};
        vecs[1] = '{1'b0, 16'hFF00, 8'h00, 8'h4F, 1'b0, 2, 2, 0, 0};
        vecs[2] = '{1'b0, 16'hFEFF, 8'h00, 8'h01, 1'b0, 3, 0, 3, 0};
        vecs[3] = '{1'b1, 16'h1234, 8'hA5, 8'h01, 1'b0, 3, 0, 3, 3};
        vecs[4] = '{1'b1, 16'hFF10, 8'h55, 8'h01, 1'b1, 0, 0, 0, 0};
        vecs[5] = '{1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0, 3, 0, 3, 0};
        vecs[6] = '{1'b0, 16'hFFFF, 8'h00, 8'hA5, 1'b0, 2, 2, 0, 0};

        repeat (3) @(negedge clk);
        chk("reset cpu_ack", cpu_ack, 0);
        chk("reset bus_err", bus_err, 0);
        chk("reset cpu_rdata", cpu_rdata, 8'h00);
        chk("reset rom_sel", rom_sel, 0);
        chk("reset rom_a", rom_a, 8'h00);
        chk("reset ram_cs_n", ram_cs_n, 1);
        chk("reset ram_we_n", ram_we_n, 1);
        chk("reset ram_a", ram_a, 16'h0000);
        chk("reset ram_dq_o", ram_dq_o, 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0);
            check_txn($sformatf("vec%0d", i), vecs[i]);
        end
        ref_mem[int'(16'h1234)] = 8'hA5;
        ref_rdata = 8'hA5;

        // A second request during ACCESS must be dropped.
        run_txn(1'b0, 16'h0040, 8'h00, 1'b1);
        check_txn("ignored req", predict(1'b0, 16'h0040, 8'h00));

        for (int i = 0; i < 60; i++) begin
            logic [15:0] a;
            logic        w;
            logic [7:0]  d;
            vec_t        v;
            case ($urandom_range(3))
                0: a = {8'hFF, 8'($urandom)};
                1: a = {8'hFE, 8'($urandom)};
                2: a = {12'h012, 4'($urandom)};
                default: a = 16'($urandom);
            endcase
            w = 1'($urandom);
            d = 8'($urandom);
            v = predict(w, a, d);
            run_txn(w, a, d, 1'b0);
            check_txn($sformatf("rand%0d @%04h we=%0d", i, a, w), v);
        end

        // Reset during a RAM read: strobes drop asynchronously, no ack appears.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2000;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        @(posedge clk);
        #2 chk("mid-access cs before reset", ram_cs_n, 0);
        rst_n = 1'b0;
        #1;
        chk("async reset ram_cs_n", ram_cs_n, 1);
        chk("async reset ram_we_n", ram_we_n, 1);
        begin
            int acks = 0;
            for (int n = 0; n < 4; n++) begin
                @(negedge clk);
                if (cpu_ack) acks++;
            end
            rst_n = 1'b1;
            for (int n = 0; n < 4; n++) begin
                @(negedge clk);
                if (cpu_ack) acks++;
            end
            chk("no ack after reset", acks, 0);
        end
        chk("rdata cleared by reset", cpu_rdata, 8'h00);
        ref_rdata = 8'h00;
        run_txn(1'b0, 16'h2000, 8'h00, 1'b0);
        check_txn("post-reset read", predict(1'b0, 16'h2000, 8'h00));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
